// File: rtl/tge_tx_arb_pkg.sv
// Shared types and helpers for the gbe0 TX packet arbiter.
// Holds the FSM state encoding, destination field widths and the round-robin step.
package tge_tx_arb_pkg;

  localparam int IP_W   = 32;
  localparam int PORT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  // Index following idx, wrapping n-1 back to 0.
  function automatic int rr_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tge_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after ptr,
// wrapping N-1 -> 0, plus a flag telling whether any request is present.
module tge_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/tge_tx_arbiter.sv
// Whole-packet round-robin arbiter feeding the gbe0 TX core, with TX beat/packet counters.
// Define TGE_TX_ARB_MAXLEN_EN to truncate packets longer than MAX_BEATS and drain their tail.
module tge_tx_arbiter
  import tge_tx_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 1024
) (
  input  logic                       user_clk,
  input  logic                       user_rst,
  input  logic                       enable,
  input  logic                       cnt_rst,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  input  logic [N_SRC-1:0]           src_eof,
  input  logic [N_SRC*IP_W-1:0]      src_dest_ip,
  input  logic [N_SRC*PORT_W-1:0]    src_dest_port,
  output logic [N_SRC-1:0]           src_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  output logic                       tx_end_of_frame,
  output logic [IP_W-1:0]            tx_dest_ip,
  output logic [PORT_W-1:0]          tx_dest_port,
  input  logic                       tx_afull,
  output logic [31:0]                txvld_count,
  output logic [31:0]                txpkt_count,
  output logic [15:0]                trunc_count,
  output arb_state_t                 state_dbg,
  output logic [$clog2(N_SRC)-1:0]   ptr_dbg
);

  localparam int PTR_W  = $clog2(N_SRC);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
`ifdef TGE_TX_ARB_MAXLEN_EN
  localparam bit MAXLEN_EN = 1'b1;
`else
  localparam bit MAXLEN_EN = 1'b0;
`endif

  arb_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  g;
  logic [PTR_W-1:0]  pick;
  logic              pick_any;
  logic [BEAT_W-1:0] beat_cnt;
  logic [15:0]       trunc_q;
  logic              accept;
  logic              last_beat;
  logic              at_limit;
  logic              trunc_evt;
  logic [DATA_W-1:0] g_data;
  logic [PTR_W-1:0]  g_next;

  tge_rr_pick #(.N(N_SRC), .PTR_W(PTR_W)) u_pick (
    .req   (src_valid),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );

  // Handshake: a source beat moves when src_valid[i] && src_ready[i] at a rising edge;
  // only the granted source ever sees ready, and it never waits on its own valid.
  always_comb begin
    src_ready = '0;
    if (state == STREAM) src_ready[g] = !tx_afull;
    else if (state == DRAIN) src_ready[g] = 1'b1;
  end

  assign accept    = src_valid[g] & src_ready[g];
  assign last_beat = src_eof[g];
  assign at_limit  = MAXLEN_EN && (beat_cnt == BEAT_W'(MAX_BEATS - 1));
  assign trunc_evt = (state == STREAM) && accept && !last_beat && at_limit;
  assign g_data    = src_data[int'(g)*DATA_W +: DATA_W];
  assign g_next    = PTR_W'(rr_next_idx(int'(g), N_SRC));

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state           <= IDLE;
      ptr             <= '0;
      g               <= '0;
      beat_cnt        <= '0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
    end else begin
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pick_any) begin
            g            <= pick;
            tx_dest_ip   <= src_dest_ip[int'(pick)*IP_W +: IP_W];
            tx_dest_port <= src_dest_port[int'(pick)*PORT_W +: PORT_W];
            beat_cnt     <= '0;
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            tx_data  <= g_data;
            tx_valid <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              tx_end_of_frame <= 1'b1;
              ptr             <= g_next;
              state           <= IDLE;
            end else if (at_limit) begin
              // Over-long packet: close it on the wire, swallow the rest.
              tx_end_of_frame <= 1'b1;
              state           <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept && last_beat) begin
            ptr   <= g_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst || cnt_rst) begin
      txvld_count <= '0;
      txpkt_count <= '0;
      trunc_q     <= '0;
    end else begin
      if (tx_valid) txvld_count <= txvld_count + 32'd1;
      if (tx_valid && tx_end_of_frame) txpkt_count <= txpkt_count + 32'd1;
      if (trunc_evt && trunc_q != 16'hFFFF) trunc_q <= trunc_q + 16'd1;
    end
  end

  assign trunc_count = trunc_q;
  assign state_dbg   = state;
  assign ptr_dbg     = ptr;

endmodule

// File: doc/tge_tx_arbiter.md
# tge_tx_arbiter

Round-robin packet arbiter that shares the single 10GbE transmit port (gbe0) among N_SRC fabric packet sources with whole-packet granularity. It sits between the user datapath and the ten_gbe core's TX interface. It also produces the TX-valid beat counter and packet counter that drive the `user_data_in` inputs of the `gbe0_txvldctr` and `gbe0_txpktctr` simulink2ppc software registers.

## Interface
- N_SRC, 4, number of requesting sources (2..8)
- DATA_W, 64, TX data width
- MAX_BEATS, 1024, maximum beats per packet (used only with TGE_TX_ARB_MAXLEN_EN)

- user_clk  in  1  TX fabric clock; all logic on rising edge
- user_rst  in  1  reset, synchronous, active-high
- enable  in  1  allow new grants; a packet in flight always completes
- cnt_rst  in  1  synchronous clear of both counters
- src_valid  in  N_SRC  per-source beat valid
- src_data  in  N_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
- src_eof  in  N_SRC  per-source end-of-frame, qualified by src_valid
- src_dest_ip  in  N_SRC*32  per-source destination IP
- src_dest_port  in  N_SRC*16  per-source destination UDP port
- src_ready  out  N_SRC  per-source beat accept
- tx_data  out  DATA_W  to core tx_data
- tx_valid  out  1  to core tx_valid
- tx_end_of_frame  out  1  to core tx_end_of_frame
- tx_dest_ip  out  32  to core tx_dest_ip
- tx_dest_port  out  16  to core tx_dest_port
- tx_afull  in  1  core TX buffer almost full
- txvld_count  out  32  TX-valid beats sent; feeds txvldctr user_data_in
- txpkt_count  out  32  packets sent; feeds txpktctr user_data_in
- trunc_count  out  16  packets truncated (zero when macro absent)

## Operation
- States: IDLE, STREAM.
- IDLE: if enable=1 and any src_valid=1, grant the first requester at or after `ptr` (round-robin, wrapping N_SRC-1 -> 0). Latch grant index `g`, src_dest_ip[g] and src_dest_port[g]. Go to STREAM. src_ready is all 0 in IDLE.
- STREAM: src_ready[g] = !tx_afull; all other ready bits are 0. A beat is accepted when src_valid[g] & src_ready[g].
- An accepted beat with src_eof[g]=1 transitions to IDLE and sets ptr = (g+1) mod N_SRC.
- Destination fields are held stable from grant until the cycle after EOF is output.
- enable deasserting mid-packet has no effect until EOF; IDLE then stops granting.
- txvld_count increments on every cycle with tx_valid=1. txpkt_count increments on every cycle with tx_valid & tx_end_of_frame. Both wrap 2^32-1 -> 0. cnt_rst=1 clears both and takes priority over a same-cycle increment.
- A source may drop src_valid mid-packet; the arbiter stays in STREAM on g (no other source is granted).

## Timing
- Reset values:
  - All outputs 0, including src_ready, tx_valid, all counters, tx_dest_*.
  - State IDLE, ptr=0.
- Grant latency: requester valid in IDLE at cycle t -> src_ready[g] may be 1 at t+1.
- Data latency: beat accepted at cycle t -> tx_data/tx_valid/tx_end_of_frame registered at t+1. The counter updates at t+2.
- Back-pressure: tx_afull sampled combinationally into src_ready. The core's afull slack absorbs the one registered beat.
- Back-to-back packets: EOF accepted at t -> IDLE at t+1 -> next grant ready at t+2. The minimum inter-packet gap on tx_valid is one cycle.
- Reset mid-packet: everything clears next edge. No EOF is emitted; the core is reset by the same user_rst.

## Configuration
- TGE_TX_ARB_MAXLEN_EN defined:
  - A beat counter per packet is kept.
  - On the MAX_BEATS-th accepted beat without src_eof, tx_end_of_frame is forced to 1 and trunc_count is incremented (saturating at 0xFFFF; cleared by cnt_rst).
  - The arbiter then enters a DRAIN state: src_ready[g]=1 and beats are discarded until src_eof[g] is accepted, then IDLE.
- Undefined: no length limit, no DRAIN state, trunc_count tied to 0.

## Structure
- Package `tge_tx_arb_pkg`:
  - state enum (IDLE, STREAM, DRAIN)
  - IP/port width constants
  - round-robin next-index function
- One sub-module, `tge_rr_pick`: combinational N_SRC-wide round-robin priority picker (req, ptr -> grant index, any).
- Counters stay inline.

## Test plan
- Single source 0 sends a 4-beat packet (data 1..4, EOF on beat 4, IP 0x0A000001, port 60000) -> tx_valid for 4 consecutive cycles with data 1..4, EOF on the 4th beat, dest fields held; txvld_count=4, txpkt_count=1.
- All 4 sources request continuously, 2-beat packets -> grants in order 0,1,2,3,0 with one idle cycle between packets; no interleaving within a packet.
- tx_afull held high for 5 cycles mid-packet -> no src_ready for those cycles; no beats lost or duplicated, order preserved.
- cnt_rst pulsed in the same cycle as tx_valid with txvld_count=0xFFFFFFFF -> count reads 0. Without cnt_rst the count wraps to 0.
- user_rst asserted on beat 2 of a 6-beat packet -> next cycle all outputs 0, state IDLE, ptr=0; a fresh request from source 2 is granted normally.
- With TGE_TX_ARB_MAXLEN_EN and MAX_BEATS=8, a 12-beat packet -> 8 tx beats with forced EOF on the 8th, 4 beats drained, trunc_count=1, txpkt_count=1.
